// File: rtl/i_mem_fetch_responder.sv
// Instruction-fetch responder: queues fetch PCs in order, reads each from a synchronous memory port, returns it with fetch_valid.
// Optional per-cycle debug print enabled by defining I_MEM_FETCH_RESPONDER_SCAN_EN.
module i_mem_fetch_responder #(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 20,
  parameter int LATENCY         = 2,
  parameter int QUEUE_DEPTH     = 4,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issue_request,
  input  logic [ADDRESS_BITS-1:0] issue_PC,
  output logic                    fetch_ready,
  output logic                    fetch_valid,
  output logic [ADDRESS_BITS-1:0] fetch_address_out,
  output logic [DATA_WIDTH-1:0]   fetch_instruction,
  output logic                    mem_read,
  output logic [ADDRESS_BITS-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0]   mem_readdata,
  input  logic                    scan
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

  state_t                  state, state_next;
  logic [ADDRESS_BITS-1:0] entries [QUEUE_DEPTH];
  logic [PTR_W-1:0]        head, tail;
  logic [PTR_W:0]          count, count_next;
  logic [3:0]              wait_count, wait_count_next;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    capture;
  logic [ADDRESS_BITS-1:0] addr_hold, mem_addr_hold;
  logic [DATA_WIDTH-1:0]   instr_hold;
  logic                    full, push, pop, read_active, resp_active;
  logic [ADDRESS_BITS-1:0] head_addr;
  logic [DATA_WIDTH-1:0]   resp_data;

  assign full        = (count == (PTR_W+1)'(QUEUE_DEPTH));
  assign fetch_ready = reset & ~full;
  assign push        = issue_request & fetch_ready;
  assign pop         = (state == RESP);
  assign head_addr   = entries[head];
  assign read_active = reset & (state == READ);
  assign resp_active = reset & (state == RESP);
  // With LATENCY==2 the response cycle is the one where mem_readdata is still live, so bypass the data register.
  assign resp_data   = capture ? mem_readdata : data_reg;

  assign mem_read          = read_active;
  assign mem_address       = read_active ? head_addr : mem_addr_hold;
  assign fetch_valid       = resp_active;
  assign fetch_address_out = resp_active ? head_addr : addr_hold;
  assign fetch_instruction = resp_active ? resp_data : instr_hold;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + (PTR_W+1)'(1);
    else if (pop && !push) count_next = count - (PTR_W+1)'(1);
  end

  // IDLE looks at the post-edge occupancy so a request accepted now is read in the very next cycle.
  always_comb begin
    state_next      = state;
    wait_count_next = wait_count;
    case (state)
      IDLE: if (count_next != '0) state_next = READ;
      READ: begin
        if (LATENCY > 2) begin
          state_next      = WAIT;
          wait_count_next = 4'(LATENCY - 2);
        end else begin
          state_next = RESP;
        end
      end
      WAIT: begin
        if (wait_count == 4'd1) state_next = RESP;
        else                    wait_count_next = wait_count - 4'd1;
      end
      RESP:    state_next = (count_next != '0) ? READ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      entries       <= '{default: '0};
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      wait_count    <= '0;
      data_reg      <= '0;
      capture       <= 1'b0;
      addr_hold     <= '0;
      instr_hold    <= '0;
      mem_addr_hold <= '0;
    end else begin
      state      <= state_next;
      wait_count <= wait_count_next;
      count      <= count_next;
      capture    <= (state == READ);
      if (capture) data_reg <= mem_readdata;
      if (push) begin
        entries[tail] <= issue_PC;
        tail          <= tail + PTR_W'(1);
      end
      if (pop) begin
        head       <= head + PTR_W'(1);
        addr_hold  <= head_addr;
        instr_hold <= resp_data;
      end
      if (state == READ) mem_addr_hold <= head_addr;
    end
  end

`ifdef I_MEM_FETCH_RESPONDER_SCAN_EN
  logic [31:0] cycles;

  always_ff @(posedge clock) begin
    if (!reset) cycles <= '0;
    else        cycles <= cycles + 32'd1;
    if (scan && cycles >= 32'(SCAN_CYCLES_MIN) && cycles <= 32'(SCAN_CYCLES_MAX))
      $display("core %0d cycle %0d state %s count %0d head %0d tail %0d ready %b valid %b addr %h instr %h",
               CORE, cycles, state.name(), count, head, tail, fetch_ready, fetch_valid,
               fetch_address_out, fetch_instruction);
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(CORE) ^ 32'(SCAN_CYCLES_MIN) ^ 32'(SCAN_CYCLES_MAX) ^ {31'b0, scan};
`endif

endmodule

// File: tb/tb_i_mem_fetch_responder.sv
// Scoreboard bench for i_mem_fetch_responder: LATENCY=2 main instance with randomized traffic, plus a LATENCY=5 instance.
`timescale 1ns/1ps
module tb_i_mem_fetch_responder;
  localparam int AB    = 20;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int LAT5  = 5;

  typedef struct {
    int            r;
    logic [AB-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clock = 1'b0, reset = 1'b0, scan = 1'b0;
  logic          issue_request = 1'b0;
  logic [AB-1:0] issue_PC = '0;
  logic          fetch_ready, fetch_valid, mem_read;
  logic [AB-1:0] fetch_address_out, mem_address;
  logic [DW-1:0] fetch_instruction, mem_readdata = '0;

  logic          issue5 = 1'b0;
  logic [AB-1:0] pc5 = '0;
  logic          ready5, valid5, mem_read5;
  logic [AB-1:0] addr5, mem_address5;
  logic [DW-1:0] instr5, mem_readdata5 = '0;

  int   cyc = 0, vectors = 0, miscompares = 0, last_r = -100, n5 = -1;
  logic exp_ready = 1'b0, run = 1'b0;
  exp_t sb[$];
  int   occ_q[$];
  exp_t got_e;

  i_mem_fetch_responder #(.LATENCY(LAT), .QUEUE_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .issue_request(issue_request), .issue_PC(issue_PC),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_address_out(fetch_address_out),
    .fetch_instruction(fetch_instruction), .mem_read(mem_read), .mem_address(mem_address),
    .mem_readdata(mem_readdata), .scan(scan));

  i_mem_fetch_responder #(.LATENCY(LAT5), .QUEUE_DEPTH(DEPTH)) dut5 (
    .clock(clock), .reset(reset), .issue_request(issue5), .issue_PC(pc5),
    .fetch_ready(ready5), .fetch_valid(valid5), .fetch_address_out(addr5),
    .fetch_instruction(instr5), .mem_read(mem_read5), .mem_address(mem_address5),
    .mem_readdata(mem_readdata5), .scan(scan));

  function automatic logic [DW-1:0] mem_word(input logic [AB-1:0] a);
    return {12'h0, a} ^ 32'hA5A50000;
  endfunction

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (mem_read)  mem_readdata  <= mem_word(mem_address);
  always @(posedge clock) if (mem_read5) mem_readdata5 <= mem_word(mem_address5);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  // Reference model: a request accepted in cycle c responds in max(c, previous response) + LAT;
  // it occupies a queue slot from c+1 through its response cycle.
  task automatic step(input logic rst, input logic req, input logic [AB-1:0] pc);
    int   c, r;
    exp_t e;
    @(posedge clock);
    #1;
    c = cyc;
    while (occ_q.size() != 0 && occ_q[0] < c) void'(occ_q.pop_front());
    reset         = rst;
    issue_request = req;
    issue_PC      = pc;
    if (!rst) begin
      occ_q.delete();
      sb.delete();
      last_r    = -100;
      exp_ready = 1'b0;
    end else begin
      exp_ready = (occ_q.size() < DEPTH);
      if (req && exp_ready) begin
        r      = (c > last_r) ? c + LAT : last_r + LAT;
        last_r = r;
        occ_q.push_back(r);
        e.r    = r;
        e.addr = pc;
        e.data = mem_word(pc);
        sb.push_back(e);
      end
    end
    run = 1'b1;
  endtask

  always @(negedge clock) if (run) begin
    chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, exp_ready});
    if (mem_read) begin
      if (sb.size() == 0) chk("mem_read_spurious", {31'b0, mem_read}, 32'd0);
      else begin
        chk("mem_read_cycle", cyc, sb[0].r - LAT + 1);
        chk("mem_address", {12'h0, mem_address}, {12'h0, sb[0].addr});
      end
    end
    if (fetch_valid) begin
      if (sb.size() == 0) chk("fetch_valid_spurious", {31'b0, fetch_valid}, 32'd0);
      else begin
        got_e = sb.pop_front();
        chk("resp_cycle", cyc, got_e.r);
        chk("fetch_address_out", {12'h0, fetch_address_out}, {12'h0, got_e.addr});
        chk("fetch_instruction", fetch_instruction, got_e.data);
      end
    end else if (sb.size() != 0 && sb[0].r <= cyc) begin
      chk("fetch_valid_missing", {31'b0, fetch_valid}, 32'd1);
      void'(sb.pop_front());
    end
    if (n5 >= 0 && cyc > n5 && cyc <= n5 + LAT5) begin
      chk("lat5_valid", {31'b0, valid5}, {31'b0, cyc == n5 + LAT5});
      if (cyc == n5 + LAT5) begin
        chk("lat5_address", {12'h0, addr5}, 32'h00123);
        chk("lat5_instruction", instr5, 32'hA5A50123);
      end
    end
  end

  initial begin
    logic [AB-1:0] pcs [8];
    int            i;
    pcs = '{20'h0, 20'h4, 20'h8, 20'hC, 20'h10, 20'h14, 20'h18, 20'h1C};

    step(1'b0, 1'b1, 20'h00055);
    step(1'b0, 1'b1, 20'h00055);
    step(1'b1, 1'b0, '0);
    @(negedge clock);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_fetch_address_out", {12'h0, fetch_address_out}, 32'd0);
    chk("rst_fetch_instruction", fetch_instruction, 32'd0);
    chk("rst_mem_address", {12'h0, mem_address}, 32'd0);
    chk("rst_ready5", {31'b0, ready5}, 32'd1);
    issue5 = 1'b1;
    pc5    = 20'h00123;
    n5     = cyc;
    step(1'b1, 1'b0, '0);
    issue5 = 1'b0;
    repeat (3) step(1'b1, 1'b0, '0);

    step(1'b1, 1'b1, 20'h00004);
    repeat (5) step(1'b1, 1'b0, '0);

    i = 0;
    while (i < 8) begin
      step(1'b1, 1'b1, pcs[i]);
      if (sb.size() != 0 && sb[sb.size()-1].addr == pcs[i] && sb[sb.size()-1].r == last_r
          && occ_q.size() != 0 && occ_q[occ_q.size()-1] == last_r && exp_ready) i++;
    end
    repeat (20) step(1'b1, 1'b0, '0);

    step(1'b1, 1'b1, 20'h00100);
    step(1'b1, 1'b1, 20'h00104);
    step(1'b0, 1'b1, 20'h00108);
    repeat (8) step(1'b1, 1'b0, '0);

    repeat (600)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 7, AB'($urandom));
    repeat (20) step(1'b1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
